// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace packet streamer.
// Field encodings, widths and the largest payload size.
package trdb_pkg;

    typedef enum logic [1:0] {
        F0_OPT         = 2'd0,
        F1_BRANCH_FULL = 2'd1,
        F2_ADDR_ONLY   = 2'd2,
        F3_SYNC        = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START     = 2'd0,
        SF_EXCEPTION = 2'd1,
        SF_CONTEXT   = 2'd2,
        SF_SUPPORT   = 2'd3
    } trdb_f_sync_subformat_e;

    typedef enum logic [1:0] {
        QS_NO_CHANGE   = 2'd0,
        QS_ENDED_REP   = 2'd1,
        QS_TRACE_LOST  = 2'd2,
        QS_ENDED_NTR   = 2'd3
    } qual_status_e;

    typedef enum logic [2:0] {
        IOPT_DEFAULT    = 3'd0,
        IOPT_SEQ        = 3'd1,
        IOPT_IRET       = 3'd2,
        IOPT_SEQ_IRET   = 3'd3,
        IOPT_EXC        = 3'd4,
        IOPT_EXC_SEQ    = 3'd5,
        IOPT_EXC_IRET   = 3'd6,
        IOPT_ALL        = 3'd7
    } ioptions_e;

    localparam int PRIV_LEN  = 2;
    localparam int CAUSE_LEN = 5;

    // Largest packet is the exception sync with XLEN=64 (142 bits).
    localparam int MAX_PAYLOAD_BYTES = 18;

    function automatic logic [4:0] bits_to_bytes(input int bits);
        return 5'((bits + 7) / 8);
    endfunction

endpackage

// File: rtl/trdb_packet_streamer_if.sv
// Request and beat-stream bundle for the packet streamer.
// master drives requests and beat_ready; slave is the streamer.
interface trdb_packet_streamer_if
    import trdb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int BEAT_W   = 4,
    parameter int BMAP_LEN = 31
) ();
    logic                   req_valid_i;
    logic                   req_ready_o;
    trdb_format_e           format_i;
    trdb_f_sync_subformat_e subformat_i;
    logic                   branch_i;
    logic [PRIV_LEN-1:0]    priv_i;
    logic [XLEN-1:0]        iaddr_i;
    logic                   thaddr_i;
    logic [XLEN-1:0]        trap_addr_i;
    logic [CAUSE_LEN-1:0]   cause_i;
    logic                   interrupt_i;
    logic [XLEN-1:0]        tval_i;
    logic                   ienable_i;
    logic                   encoder_mode_i;
    qual_status_e           qual_status_i;
    ioptions_e              ioptions_i;
    logic                   updiscon_i;
    logic [4:0]             branches_i;
    logic [BMAP_LEN-1:0]    branch_map_i;
    logic                   beat_valid_o;
    logic                   beat_ready_i;
    logic [8*BEAT_W-1:0]    beat_data_o;
    logic                   beat_last_o;
    logic [3:0]             beat_bytes_o;
    logic [4:0]             pkt_len_o;
    logic                   branch_map_flush_o;
    logic                   err_o;

    modport master (
        output req_valid_i, format_i, subformat_i, branch_i, priv_i,
               iaddr_i, thaddr_i, trap_addr_i, cause_i, interrupt_i,
               tval_i, ienable_i, encoder_mode_i, qual_status_i,
               ioptions_i, updiscon_i, branches_i, branch_map_i,
               beat_ready_i,
        input  req_ready_o, beat_valid_o, beat_data_o, beat_last_o,
               beat_bytes_o, pkt_len_o, branch_map_flush_o, err_o
    );

    modport slave (
        input  req_valid_i, format_i, subformat_i, branch_i, priv_i,
               iaddr_i, thaddr_i, trap_addr_i, cause_i, interrupt_i,
               tval_i, ienable_i, encoder_mode_i, qual_status_i,
               ioptions_i, updiscon_i, branches_i, branch_map_i,
               beat_ready_i,
        output req_ready_o, beat_valid_o, beat_data_o, beat_last_o,
               beat_bytes_o, pkt_len_o, branch_map_flush_o, err_o
    );
endinterface

// File: rtl/trdb_payload_packer.sv
// Combinational LSB-first packet packing and byte length.
// TRDB_DELTA_ADDR_EN selects delta addresses for F1/F2.
module trdb_payload_packer
    import trdb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int BMAP_LEN = 31,
    parameter int PW       = 8 * MAX_PAYLOAD_BYTES
) (
    input  trdb_format_e           format_i,
    input  trdb_f_sync_subformat_e subformat_i,
    input  logic                   branch_i,
    input  logic [PRIV_LEN-1:0]    priv_i,
    input  logic [XLEN-1:0]        iaddr_i,
    input  logic                   thaddr_i,
    input  logic [XLEN-1:0]        trap_addr_i,
    input  logic [CAUSE_LEN-1:0]   cause_i,
    input  logic                   interrupt_i,
    input  logic [XLEN-1:0]        tval_i,
    input  logic                   ienable_i,
    input  logic                   encoder_mode_i,
    input  qual_status_e           qual_status_i,
    input  ioptions_e              ioptions_i,
    input  logic                   updiscon_i,
    input  logic [4:0]             branches_i,
    input  logic [BMAP_LEN-1:0]    branch_map_i,
    input  logic [XLEN-1:0]        latest_addr_i,
    output logic [PW-1:0]          payload_o,
    output logic [4:0]             len_o,
    output logic                   addr_upd_o,
    output logic [XLEN-1:0]        addr_o,
    output logic                   flush_o
);
    localparam int SF0_BITS = 4 + 1 + PRIV_LEN + XLEN;
    localparam int SF1_BITS = 4 + 1 + PRIV_LEN + CAUSE_LEN + 2 + 2 * XLEN;
    localparam int SF2_BITS = 4 + PRIV_LEN;
    localparam int SF3_BITS = 4 + 1 + 1 + 2 + 3;
    localparam int F2_BITS  = 2 + XLEN + 2;
    localparam int F1A_BITS = 2 + 5 + BMAP_LEN + XLEN + 2;
    localparam int F1N_BITS = 2 + 5 + BMAP_LEN;

    logic [XLEN-1:0] addr;
    logic            notify;
    logic            upd_bit;
    logic            f1_addr;

`ifdef TRDB_DELTA_ADDR_EN
    assign addr = iaddr_i - latest_addr_i;
`else
    logic unused_latest;
    assign unused_latest = ^latest_addr_i;
    assign addr = iaddr_i;
`endif

    assign notify  = addr[XLEN-1];
    assign upd_bit = updiscon_i ? ~notify : notify;
    assign f1_addr = int'(branches_i) < BMAP_LEN;

    // Field concatenations list the last-packed field first.
    always_comb begin
        payload_o  = '0;
        len_o      = '0;
        addr_upd_o = 1'b0;
        addr_o     = iaddr_i;
        flush_o    = 1'b0;
        unique case (format_i)
            F3_SYNC: begin
                unique case (subformat_i)
                    SF_START: begin
                        payload_o  = PW'({iaddr_i, priv_i, branch_i,
                                          subformat_i, format_i});
                        len_o      = bits_to_bytes(SF0_BITS);
                        addr_upd_o = 1'b1;
                        flush_o    = 1'b1;
                    end
                    SF_EXCEPTION: begin
                        payload_o  = PW'({tval_i, trap_addr_i, thaddr_i,
                                          interrupt_i, cause_i, priv_i,
                                          branch_i, subformat_i, format_i});
                        len_o      = bits_to_bytes(SF1_BITS);
                        addr_upd_o = 1'b1;
                        addr_o     = trap_addr_i;
                        flush_o    = 1'b1;
                    end
                    SF_CONTEXT: begin
                        payload_o = PW'({priv_i, subformat_i, format_i});
                        len_o     = bits_to_bytes(SF2_BITS);
                    end
                    SF_SUPPORT: begin
                        payload_o = PW'({ioptions_i, qual_status_i,
                                         encoder_mode_i, ienable_i,
                                         subformat_i, format_i});
                        len_o     = bits_to_bytes(SF3_BITS);
                    end
                endcase
            end
            F2_ADDR_ONLY: begin
                payload_o  = PW'({upd_bit, notify, addr, format_i});
                len_o      = bits_to_bytes(F2_BITS);
                addr_upd_o = 1'b1;
            end
            F1_BRANCH_FULL: begin
                flush_o = 1'b1;
                if (f1_addr) begin
                    payload_o  = PW'({upd_bit, notify, addr, branch_map_i,
                                      branches_i, format_i});
                    len_o      = bits_to_bytes(F1A_BITS);
                    addr_upd_o = 1'b1;
                end else begin
                    payload_o = PW'({branch_map_i, branches_i, format_i});
                    len_o     = bits_to_bytes(F1N_BITS);
                end
            end
            F0_OPT: begin
            end
        endcase
    end

endmodule

// File: rtl/trdb_packet_streamer.sv
// Accepts trace packet requests and streams them as byte beats.
// Build option TRDB_DELTA_ADDR_EN: F1/F2 carry delta addresses.
module trdb_packet_streamer
    import trdb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int BEAT_W   = 4,
    parameter int BMAP_LEN = 31
) (
    input logic                  clk_i,
    input logic                  rst_i,
    trdb_packet_streamer_if.slave bus
);
    localparam int PW = 8 * MAX_PAYLOAD_BYTES;
    localparam int DW = 8 * BEAT_W;

    typedef enum logic {IDLE, SEND} state_e;

    state_e          state_q;
    logic [PW-1:0]   payload_q;
    logic [4:0]      rem_q;
    logic [4:0]      len_q;
    logic [XLEN-1:0] latest_addr_q;
    logic            err_q;
    logic            flush_q;

    logic [PW-1:0]   pk_payload;
    logic [4:0]      pk_len;
    logic            pk_addr_upd;
    logic [XLEN-1:0] pk_addr;
    logic            pk_flush;
    logic            last_beat;

    trdb_payload_packer #(
        .XLEN     (XLEN),
        .BMAP_LEN (BMAP_LEN),
        .PW       (PW)
    ) u_packer (
        .format_i       (bus.format_i),
        .subformat_i    (bus.subformat_i),
        .branch_i       (bus.branch_i),
        .priv_i         (bus.priv_i),
        .iaddr_i        (bus.iaddr_i),
        .thaddr_i       (bus.thaddr_i),
        .trap_addr_i    (bus.trap_addr_i),
        .cause_i        (bus.cause_i),
        .interrupt_i    (bus.interrupt_i),
        .tval_i         (bus.tval_i),
        .ienable_i      (bus.ienable_i),
        .encoder_mode_i (bus.encoder_mode_i),
        .qual_status_i  (bus.qual_status_i),
        .ioptions_i     (bus.ioptions_i),
        .updiscon_i     (bus.updiscon_i),
        .branches_i     (bus.branches_i),
        .branch_map_i   (bus.branch_map_i),
        .latest_addr_i  (latest_addr_q),
        .payload_o      (pk_payload),
        .len_o          (pk_len),
        .addr_upd_o     (pk_addr_upd),
        .addr_o         (pk_addr),
        .flush_o        (pk_flush)
    );

    assign last_beat = rem_q <= 5'(BEAT_W);

    // Request capture, beat shifting and single-cycle status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            payload_q     <= '0;
            rem_q         <= '0;
            len_q         <= '0;
            latest_addr_q <= '0;
            err_q         <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            err_q   <= 1'b0;
            flush_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        if (bus.format_i == F0_OPT) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q   <= SEND;
                            payload_q <= pk_payload;
                            rem_q     <= pk_len;
                            len_q     <= pk_len;
                            flush_q   <= pk_flush;
                            if (pk_addr_upd) begin
                                latest_addr_q <= pk_addr;
                            end
                        end
                    end
                end
                SEND: begin
                    if (bus.beat_ready_i) begin
                        payload_q <= payload_q >> DW;
                        if (last_beat) begin
                            rem_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            rem_q <= rem_q - 5'(BEAT_W);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.req_ready_o        = (state_q == IDLE);
    assign bus.beat_valid_o       = (state_q == SEND);
    assign bus.beat_data_o        = payload_q[DW-1:0];
    assign bus.beat_last_o        = (state_q == SEND) && last_beat;
    assign bus.beat_bytes_o       = (state_q != SEND) ? 4'd0 :
                                    last_beat ? 4'(rem_q) : 4'(BEAT_W);
    assign bus.pkt_len_o          = len_q;
    assign bus.branch_map_flush_o = flush_q;
    assign bus.err_o              = err_q;

endmodule

// File: tb/tb_trdb_packet_streamer.sv
// Randomized and directed bench for trdb_packet_streamer.
// Reference model packs fields as a plain bit list.
module tb_trdb_packet_streamer;
    import trdb_pkg::*;

    localparam int XLEN     = 32;
    localparam int BEAT_W   = 4;
    localparam int BMAP_LEN = 31;
    localparam int DW       = 8 * BEAT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    trdb_packet_streamer_if #(
        .XLEN(XLEN), .BEAT_W(BEAT_W), .BMAP_LEN(BMAP_LEN)
    ) bus ();

    trdb_packet_streamer #(
        .XLEN(XLEN), .BEAT_W(BEAT_W), .BMAP_LEN(BMAP_LEN)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        trdb_format_e           fmt;
        trdb_f_sync_subformat_e sub;
        logic                   branch;
        logic [1:0]             priv;
        logic [XLEN-1:0]        iaddr;
        logic [XLEN-1:0]        trap_addr;
        logic [XLEN-1:0]        tval;
        logic                   thaddr;
        logic [4:0]             cause;
        logic                   intr;
        logic                   ien;
        logic                   emode;
        logic [1:0]             qs;
        logic [2:0]             iopt;
        logic                   updiscon;
        logic [4:0]             branches;
        logic [BMAP_LEN-1:0]    bmap;
    } req_t;

    // ---------------- reference model ----------------
    logic [XLEN-1:0] mdl_latest = '0;
    logic [7:0]      exp_bytes[$];
    bit              exp_flush;
    bit              mbits[$];

    function automatic void put(input logic [63:0] v, input int w);
        for (int i = 0; i < w; i++) mbits.push_back(v[i]);
    endfunction

    function automatic void model(input req_t r);
        logic [XLEN-1:0] a;
        logic            n;
        logic [7:0]      by;
        mbits.delete();
        exp_bytes.delete();
        exp_flush = 1'b0;
`ifdef TRDB_DELTA_ADDR_EN
        a = r.iaddr - mdl_latest;
`else
        a = r.iaddr;
`endif
        n = a[XLEN-1];
        put(64'(r.fmt), 2);
        if (r.fmt == F3_SYNC) begin
            put(64'(r.sub), 2);
            case (r.sub)
                SF_START: begin
                    put(64'(r.branch), 1); put(64'(r.priv), 2);
                    put(64'(r.iaddr), XLEN);
                    mdl_latest = r.iaddr; exp_flush = 1'b1;
                end
                SF_EXCEPTION: begin
                    put(64'(r.branch), 1); put(64'(r.priv), 2);
                    put(64'(r.cause), 5); put(64'(r.intr), 1);
                    put(64'(r.thaddr), 1); put(64'(r.trap_addr), XLEN);
                    put(64'(r.tval), XLEN);
                    mdl_latest = r.trap_addr; exp_flush = 1'b1;
                end
                SF_CONTEXT: put(64'(r.priv), 2);
                default: begin
                    put(64'(r.ien), 1); put(64'(r.emode), 1);
                    put(64'(r.qs), 2); put(64'(r.iopt), 3);
                end
            endcase
        end else if (r.fmt == F2_ADDR_ONLY) begin
            put(64'(a), XLEN); put(64'(n), 1);
            put(64'(r.updiscon ? ~n : n), 1);
            mdl_latest = r.iaddr;
        end else if (r.fmt == F1_BRANCH_FULL) begin
            put(64'(r.branches), 5); put(64'(r.bmap), BMAP_LEN);
            exp_flush = 1'b1;
            if (r.branches < BMAP_LEN) begin
                put(64'(a), XLEN); put(64'(n), 1);
                put(64'(r.updiscon ? ~n : n), 1);
                mdl_latest = r.iaddr;
            end
        end
        for (int b = 0; b < (mbits.size() + 7) / 8; b++) begin
            by = '0;
            for (int i = 0; i < 8; i++)
                if (b * 8 + i < mbits.size()) by[i] = mbits[b * 8 + i];
            exp_bytes.push_back(by);
        end
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int k);
        logic [DW-1:0] e;
        e = '0;
        for (int j = 0; j < BEAT_W; j++)
            if (k * BEAT_W + j < exp_bytes.size())
                e[j*8 +: 8] = exp_bytes[k * BEAT_W + j];
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.fmt       = trdb_format_e'(2'($urandom_range(1, 3)));
        r.sub       = trdb_f_sync_subformat_e'(2'($urandom_range(0, 3)));
        r.branch    = 1'($urandom);
        r.priv      = 2'($urandom);
        r.iaddr     = $urandom;
        r.trap_addr = $urandom;
        r.tval      = $urandom;
        r.thaddr    = 1'($urandom);
        r.cause     = 5'($urandom);
        r.intr      = 1'($urandom);
        r.ien       = 1'($urandom);
        r.emode     = 1'($urandom);
        r.qs        = 2'($urandom);
        r.iopt      = 3'($urandom);
        r.updiscon  = 1'($urandom);
        r.branches  = 5'($urandom_range(0, 31));
        r.bmap      = BMAP_LEN'($urandom);
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic apply(input req_t r);
        bus.format_i       = r.fmt;
        bus.subformat_i    = r.sub;
        bus.branch_i       = r.branch;
        bus.priv_i         = r.priv;
        bus.iaddr_i        = r.iaddr;
        bus.thaddr_i       = r.thaddr;
        bus.trap_addr_i    = r.trap_addr;
        bus.cause_i        = r.cause;
        bus.interrupt_i    = r.intr;
        bus.tval_i         = r.tval;
        bus.ienable_i      = r.ien;
        bus.encoder_mode_i = r.emode;
        bus.qual_status_i  = qual_status_e'(r.qs);
        bus.ioptions_i     = ioptions_e'(r.iopt);
        bus.updiscon_i     = r.updiscon;
        bus.branches_i     = r.branches;
        bus.branch_map_i   = r.bmap;
    endtask

    // Models the packet, then holds req_valid until accepted.
    // Returns on the falling edge after the accepting edge.
    task automatic send(input req_t r);
        bit ok;
        model(r);
        apply(r);
        bus.req_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.req_ready_o) ok = 1'b1;
            @(negedge clk);
        end
        bus.req_valid_i = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL req_accept: got no handshake, want accept within 200 cycles");
        end
    endtask

    logic [DW-1:0] col_data[$];
    int            col_bytes[$];
    bit            col_last[$];
    int            col_len;
    bit            col_len_moved;
    bit            col_done;

    // Gathers beats until beat_last; random back-pressure optional.
    task automatic collect(input bit rand_rdy);
        bit rdy;
        col_data.delete();
        col_bytes.delete();
        col_last.delete();
        col_done      = 1'b0;
        col_len       = int'(bus.pkt_len_o);
        col_len_moved = 1'b0;
        for (int c = 0; c < 400 && !col_done; c++) begin
            rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.beat_ready_i = rdy;
            if (int'(bus.pkt_len_o) != col_len) col_len_moved = 1'b1;
            if (bus.beat_valid_o && rdy) begin
                col_data.push_back(bus.beat_data_o);
                col_bytes.push_back(int'(bus.beat_bytes_o));
                col_last.push_back(bus.beat_last_o);
                if (bus.beat_last_o) col_done = 1'b1;
            end
            @(negedge clk);
        end
        bus.beat_ready_i = 1'b0;
        tests++;
        if (!col_done) begin
            fails++;
            $display("FAIL beat_timeout: got %0d beats, no last within 400 cycles",
                     col_data.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests++;
        if (bus.req_ready_o !== 1'b1 || bus.beat_valid_o !== 1'b0 ||
            bus.err_o !== 1'b0 || bus.branch_map_flush_o !== 1'b0 ||
            bus.pkt_len_o !== 5'd0 || bus.beat_data_o !== '0 ||
            bus.beat_last_o !== 1'b0 || bus.beat_bytes_o !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b err=%b fl=%b len=%0d, want 1 0 0 0 0",
                     bus.req_ready_o, bus.beat_valid_o, bus.err_o,
                     bus.branch_map_flush_o, bus.pkt_len_o);
        end
    endtask

    task automatic test_f3sf0();
        req_t r;
        r = rand_req();
        r.fmt = F3_SYNC; r.sub = SF_START; r.branch = 1'b1;
        r.priv = 2'd3; r.iaddr = 32'h8000_0100;
        send(r);
        tests++;
        if (bus.branch_map_flush_o !== 1'b1) begin
            fails++;
            $display("FAIL sf0_flush: got %b want 1", bus.branch_map_flush_o);
        end
        collect(1'b0);
        tests++;
        if (col_len !== 5 || col_data.size() != 2) begin
            fails++;
            $display("FAIL sf0_len: got len=%0d beats=%0d want 5 2",
                     col_len, col_data.size());
        end else begin
            tests++;
            if (col_data[0] !== 32'h0000_8073 || col_data[1] !== 32'h0000_0040) begin
                fails++;
                $display("FAIL sf0_data: got %h %h want 00008073 00000040",
                         col_data[0], col_data[1]);
            end
            tests++;
            if (col_bytes[0] != 4 || col_bytes[1] != 1 ||
                col_last[0] != 1'b0 || col_last[1] != 1'b1) begin
                fails++;
                $display("FAIL sf0_bytes_last: got %0d/%b %0d/%b want 4/0 1/1",
                         col_bytes[0], col_last[0], col_bytes[1], col_last[1]);
            end
        end
        tests++;
        if (bus.branch_map_flush_o !== 1'b0) begin
            fails++;
            $display("FAIL sf0_flush_pulse: got %b want 0", bus.branch_map_flush_o);
        end
    endtask

    task automatic test_stall();
        req_t r;
        r = rand_req();
        r.fmt = F3_SYNC; r.sub = SF_START; r.branch = 1'b1;
        r.priv = 2'd3; r.iaddr = 32'h8000_0100;
        send(r);
        bus.beat_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.beat_valid_o !== 1'b1 || bus.beat_data_o !== 32'h0000_8073) begin
                fails++;
                $display("FAIL stall_hold: cycle %0d got vld=%b data=%h want 1 00008073",
                         i, bus.beat_valid_o, bus.beat_data_o);
            end
            if (i == 3) bus.beat_ready_i = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (bus.beat_data_o !== 32'h0000_0040 || bus.beat_last_o !== 1'b1) begin
            fails++;
            $display("FAIL stall_advance: got data=%h last=%b want 00000040 1",
                     bus.beat_data_o, bus.beat_last_o);
        end
        @(negedge clk);
        bus.beat_ready_i = 1'b0;
        tests++;
        if (bus.req_ready_o !== 1'b1 || bus.beat_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL stall_idle: got rdy=%b vld=%b want 1 0",
                     bus.req_ready_o, bus.beat_valid_o);
        end
    endtask

    task automatic test_f0();
        req_t r;
        bit   seen_vld;
        r = rand_req();
        r.fmt = F0_OPT;
        send(r);
        tests++;
        if (bus.err_o !== 1'b1) begin
            fails++;
            $display("FAIL f0_err: got %b want 1", bus.err_o);
        end
        seen_vld = bus.beat_valid_o;
        @(negedge clk);
        tests++;
        if (bus.err_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL f0_pulse: got err=%b rdy=%b want 0 1",
                     bus.err_o, bus.req_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            seen_vld |= bus.beat_valid_o;
            @(negedge clk);
        end
        tests++;
        if (seen_vld !== 1'b0) begin
            fails++;
            $display("FAIL f0_no_beat: got beat_valid=%b want 0", seen_vld);
        end
    endtask

    task automatic test_back_to_back();
        req_t          a, b;
        logic [DW-1:0] ea[2];
        a = rand_req();
        a.fmt = F3_SYNC; a.sub = SF_START;
        b = rand_req();
        b.fmt = F3_SYNC; b.sub = SF_CONTEXT;
        send(a);
        ea[0] = exp_beat(0);
        ea[1] = exp_beat(1);
        apply(b);
        bus.req_valid_i  = 1'b1;
        bus.beat_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (bus.req_ready_o !== 1'b0 || bus.beat_data_o !== ea[i]) begin
                fails++;
                $display("FAIL b2b_send: beat %0d got rdy=%b data=%h want 0 %h",
                         i, bus.req_ready_o, bus.beat_data_o, ea[i]);
            end
            @(negedge clk);
        end
        tests++;
        if (bus.req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL b2b_idle: got rdy=%b want 1", bus.req_ready_o);
        end
        model(b);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        tests++;
        if (bus.beat_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: got vld=%b want 1", bus.beat_valid_o);
        end
        collect(1'b0);
        tests++;
        if (col_data.size() != 1 || col_data[0] !== exp_beat(0)) begin
            fails++;
            $display("FAIL b2b_second: got %0d beats, want 1 beat %h",
                     col_data.size(), exp_beat(0));
        end
    endtask

    task automatic test_delta_addr();
        req_t            r;
        logic [127:0]    pk;
        logic [XLEN-1:0] want1, want2;
`ifdef TRDB_DELTA_ADDR_EN
        want1 = 32'h0000_0100;
        want2 = 32'h0000_0100;
`else
        want1 = 32'h0000_1000;
        want2 = 32'h0000_1100;
`endif
        r = rand_req();
        r.fmt = F3_SYNC; r.sub = SF_START; r.iaddr = 32'h0000_0F00;
        send(r);
        collect(1'b1);
        r = rand_req();
        r.fmt = F1_BRANCH_FULL; r.branches = 5'd2; r.iaddr = 32'h0000_1000;
        send(r);
        collect(1'b1);
        pk = '0;
        foreach (col_data[k]) if (k < 4) pk[k*DW +: DW] = col_data[k];
        tests++;
        if (col_len != 9 || pk[38 +: XLEN] !== want1) begin
            fails++;
            $display("FAIL f1_addr: got len=%0d addr=%h want 9 %h",
                     col_len, pk[38 +: XLEN], want1);
        end
        r = rand_req();
        r.fmt = F1_BRANCH_FULL; r.branches = 5'd31; r.iaddr = 32'h0000_5555;
        send(r);
        collect(1'b1);
        tests++;
        if (col_len != 5 || col_data.size() != 2) begin
            fails++;
            $display("FAIL f1_full_map: got len=%0d beats=%0d want 5 2",
                     col_len, col_data.size());
        end
        r = rand_req();
        r.fmt = F2_ADDR_ONLY; r.iaddr = 32'h0000_1100;
        send(r);
        collect(1'b1);
        pk = '0;
        foreach (col_data[k]) if (k < 4) pk[k*DW +: DW] = col_data[k];
        tests++;
        if (pk[2 +: XLEN] !== want2) begin
            fails++;
            $display("FAIL f2_addr: got %h want %h", pk[2 +: XLEN], want2);
        end
    endtask

    task automatic test_random();
        req_t r;
        int   nb;
        for (int p = 0; p < 40; p++) begin
            r = rand_req();
            send(r);
            tests++;
            if (bus.branch_map_flush_o !== exp_flush || bus.err_o !== 1'b0) begin
                fails++;
                $display("FAIL rnd_flush: pkt %0d got fl=%b err=%b want %b 0",
                         p, bus.branch_map_flush_o, bus.err_o, exp_flush);
            end
            collect(1'b1);
            nb = (exp_bytes.size() + BEAT_W - 1) / BEAT_W;
            tests++;
            if (col_len != exp_bytes.size() || col_len_moved ||
                col_data.size() != nb) begin
                fails++;
                $display("FAIL rnd_len: pkt %0d got len=%0d beats=%0d want %0d %0d",
                         p, col_len, col_data.size(), exp_bytes.size(), nb);
            end else begin
                for (int k = 0; k < nb; k++) begin
                    tests++;
                    if (col_data[k] !== exp_beat(k) ||
                        col_last[k] != (k == nb - 1) ||
                        col_bytes[k] != ((k == nb - 1) ?
                            exp_bytes.size() - k * BEAT_W : BEAT_W)) begin
                        fails++;
                        $display("FAIL rnd_beat: pkt %0d beat %0d got %h/%0d/%b want %h",
                                 p, k, col_data[k], col_bytes[k], col_last[k],
                                 exp_beat(k));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        req_t r;
        r = rand_req();
        r.fmt = F3_SYNC; r.sub = SF_EXCEPTION;
        send(r);
        bus.beat_ready_i = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (bus.beat_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 ||
            bus.pkt_len_o !== 5'd0 || bus.beat_data_o !== '0 ||
            bus.beat_last_o !== 1'b0 || bus.beat_bytes_o !== 4'd0 ||
            bus.branch_map_flush_o !== 1'b0 || bus.err_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got vld=%b rdy=%b len=%0d data=%h want 0 1 0 0",
                     bus.beat_valid_o, bus.req_ready_o, bus.pkt_len_o,
                     bus.beat_data_o);
        end
        bus.beat_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mdl_latest = '0;
        @(negedge clk);
        r = rand_req();
        r.fmt = F3_SYNC; r.sub = SF_CONTEXT; r.priv = 2'd1;
        send(r);
        collect(1'b0);
        tests++;
        if (col_len != 1 || col_data.size() != 1 ||
            col_data[0] !== 32'h0000_001B || col_bytes[0] != 1 ||
            col_last[0] != 1'b1) begin
            fails++;
            $display("FAIL post_reset_sf2: got len=%0d beats=%0d, want 1 1 0000001b",
                     col_len, col_data.size());
        end
    endtask

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.beat_ready_i = 1'b0;
        apply(rand_req());
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_f3sf0();
        test_stall();
        test_f0();
        test_back_to_back();
        test_delta_addr();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
